// File: rtl/d_ff_pipe.sv
// d_ff_pipe: WIDTH-bit, DEPTH-stage stallable delay line with per-stage valid tags
// and a registered count of valid stages.
// Optional macro D_FF_PIPE_TAPS_EN adds the taps/taps_vld register views.
module d_ff_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_vld,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_vld,
  output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef D_FF_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]       taps,
  output logic [DEPTH-1:0]             taps_vld
`endif
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OccW-1:0]  occ_q, occ_d;

  // Next state: clear beats enable, enable shifts data and tags together, else hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_d[i] = RST_VAL;
      end
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      data_d[0] = din;
      vld_d[0]  = din_vld;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      // Valid entering minus valid leaving; stays within 0..DEPTH by construction.
      occ_d = occ_q + OccW'(din_vld) - OccW'(vld_q[DEPTH-1]);
    end
  end

  // Pipeline state registers with asynchronous flush.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= RST_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= data_d[i];
      end
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign dout     = data_q[DEPTH-1];
  assign dout_vld = vld_q[DEPTH-1];
  assign occ      = occ_q;

`ifdef D_FF_PIPE_TAPS_EN
  // Flatten stages into taps, stage i at bits [i*WIDTH +: WIDTH].
  always_comb begin
    taps = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      taps[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign taps_vld = vld_q;
`endif

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb_d_ff_pipe: directed self-checking bench for d_ff_pipe (WIDTH=8, DEPTH=4).
module tb_d_ff_pipe;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic       clr;
  logic [7:0] din;
  logic       din_vld;
  logic [7:0] dout;
  logic       dout_vld;
  logic [2:0] occ;
`ifdef D_FF_PIPE_TAPS_EN
  logic [31:0] taps;
  logic [3:0]  taps_vld;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  d_ff_pipe #(
    .WIDTH  (8),
    .DEPTH  (4),
    .RST_VAL(8'h00)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (en),
    .clr     (clr),
    .din     (din),
    .din_vld (din_vld),
    .dout    (dout),
    .dout_vld(dout_vld),
    .occ     (occ)
`ifdef D_FF_PIPE_TAPS_EN
    ,
    .taps    (taps),
    .taps_vld(taps_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                         input logic [2:0] o);
    chk({tag, ".dout"}, {24'h0, dout}, {24'h0, d});
    chk({tag, ".dout_vld"}, {31'h0, dout_vld}, {31'h0, v});
    chk({tag, ".occ"}, {29'h0, occ}, {29'h0, o});
  endtask

  initial begin
    n_rst   = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    #12;
    chk_out("reset", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Latency: single valid word, then bubbles.
    @(negedge clk);
    en = 1'b1; din = 8'hA5; din_vld = 1'b1;
    tick();
    din = 8'h00; din_vld = 1'b0;
    chk_out("lat.e1", 8'h00, 1'b0, 3'd1);
    tick();
    chk_out("lat.e2", 8'h00, 1'b0, 3'd1);
    tick();
    chk_out("lat.e3", 8'h00, 1'b0, 3'd1);
    tick();
    chk_out("lat.e4", 8'hA5, 1'b1, 3'd1);
    tick();
    chk_out("lat.e5", 8'h00, 1'b0, 3'd0);

    // Stall after the second word for three cycles.
    din = 8'h01; din_vld = 1'b1;
    tick();
    din = 8'h02;
    tick();
    chk_out("stall.pre", 8'h00, 1'b0, 3'd2);
    en = 1'b0; din = 8'h03;
    tick();
    chk_out("stall.c1", 8'h00, 1'b0, 3'd2);
    tick();
    chk_out("stall.c2", 8'h00, 1'b0, 3'd2);
    tick();
    chk_out("stall.c3", 8'h00, 1'b0, 3'd2);
    en = 1'b1;
    tick();
    chk_out("stall.w3", 8'h00, 1'b0, 3'd3);
    din = 8'h04;
    tick();
    chk_out("stall.o1", 8'h01, 1'b1, 3'd4);
    din = 8'h00; din_vld = 1'b0;
    tick();
    chk_out("stall.o2", 8'h02, 1'b1, 3'd3);
    tick();
    chk_out("stall.o3", 8'h03, 1'b1, 3'd2);
    tick();
    chk_out("stall.o4", 8'h04, 1'b1, 3'd1);
    tick();
    chk_out("stall.done", 8'h00, 1'b0, 3'd0);

    // Fill with six valid words, then drain with bubbles.
    din_vld = 1'b1;
    din = 8'h10; tick(); chk_out("fill.1", 8'h00, 1'b0, 3'd1);
    din = 8'h11; tick(); chk_out("fill.2", 8'h00, 1'b0, 3'd2);
    din = 8'h12; tick(); chk_out("fill.3", 8'h00, 1'b0, 3'd3);
    din = 8'h13; tick(); chk_out("fill.4", 8'h10, 1'b1, 3'd4);
    din = 8'h14; tick(); chk_out("fill.5", 8'h11, 1'b1, 3'd4);
    din = 8'h15; tick(); chk_out("fill.6", 8'h12, 1'b1, 3'd4);
    din = 8'h00; din_vld = 1'b0;
    tick(); chk_out("drain.1", 8'h13, 1'b1, 3'd3);
    tick(); chk_out("drain.2", 8'h14, 1'b1, 3'd2);
    tick(); chk_out("drain.3", 8'h15, 1'b1, 3'd1);
    tick(); chk_out("drain.4", 8'h00, 1'b0, 3'd0);

    // Refill, then clear with enable and a valid 0xFF offered.
    din_vld = 1'b1;
    din = 8'h21; tick();
    din = 8'h22; tick();
    din = 8'h23; tick();
    din = 8'h24; tick();
    chk_out("refill", 8'h21, 1'b1, 3'd4);
    clr = 1'b1; din = 8'hFF; din_vld = 1'b1;
    tick();
    chk_out("clr", 8'h00, 1'b0, 3'd0);
    clr = 1'b0; din = 8'h00; din_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("clr.after", 8'h00, 1'b0, 3'd0);
    end

    // Asynchronous reset mid-cycle with a full pipeline.
    din_vld = 1'b1;
    din = 8'hA1; tick();
    din = 8'hA2; tick();
    din = 8'hA3; tick();
    din = 8'hA4; tick();
    chk_out("rst.full", 8'hA1, 1'b1, 3'd4);
    en = 1'b0; din_vld = 1'b0; din = 8'h00;
    #2;
    n_rst = 1'b0;
    #1;
    chk_out("rst.async", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk_out("rst.release", 8'h00, 1'b0, 3'd0);

`ifdef D_FF_PIPE_TAPS_EN
    chk("taps.rst", taps, 32'h0000_0000);
    chk("taps_vld.rst", {28'h0, taps_vld}, 32'h0);
    en = 1'b1; din_vld = 1'b1;
    din = 8'h11; tick();
    din = 8'h22; tick();
    din = 8'h33; tick();
    din = 8'h44; tick();
    chk("taps.fill", taps, 32'h1122_3344);
    chk("taps_vld.fill", {28'h0, taps_vld}, 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_ff_pipe.md
Name: d_ff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline (delay line).
- Each stage carries a valid tag. Global enable stalls all stages; synchronous clear flushes all stages.
- Keeps a registered count of valid stages.
- Used wherever datapaths need a fixed, stallable N-cycle delay with qualification, e.g. aligning data against control latency.

Parameters:
- WIDTH, 8, data bits per stage; legal range 1 or more.
- DEPTH, 4, number of register stages (latency in enabled cycles); legal range 1 or more.
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on async reset and on sync clear.

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  shift enable; 0 = all stages hold.
- clr  input  1  synchronous clear (flush).
- din  input  WIDTH  data into stage 0.
- din_vld  input  1  valid tag for din.
- dout  output  WIDTH  data of last stage (stage DEPTH-1), registered.
- dout_vld  output  1  valid tag of last stage, registered.
- occ  output  $clog2(DEPTH+1)  number of stages whose valid tag is 1, registered.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (n_rst).
- Reset (n_rst=0, asynchronous, no clock needed):
  - all data stages = RST_VAL and all valid tags = 0.
  - dout = RST_VAL, dout_vld = 0, occ = 0.
  - Release is synchronous to the next rising clk edge.
- Priority per rising edge: n_rst, then clr, then en, then hold.
- clr=1:
  - all data stages = RST_VAL, all valid tags = 0, occ = 0.
  - Overrides en; din/din_vld offered that cycle are discarded.
- en=1, clr=0:
  - stage0 <= din, vld0 <= din_vld.
  - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i = 1..DEPTH-1.
  - Data shifts regardless of valid; the tag only qualifies it.
- en=0, clr=0: every stage and tag holds; occ holds.
- Latency: a word accepted on edge k (en=1) appears on dout/dout_vld after DEPTH enabled edges, counting edge k as the first. Disabled cycles add directly to the latency.
- DEPTH=1: a single register with tag; dout follows din one enabled edge later.
- occ (registered), on each enabled edge:
  - occ_next = occ + din_vld - vld[DEPTH-1] (the valid entering minus the valid leaving).
  - occ always equals the population count of the valid tags after the edge.
  - Range is 0..DEPTH and never wraps; reaching DEPTH needs DEPTH consecutive enabled valid inputs.
- Invalid input (din_vld=0) with en=1 inserts a bubble: data still enters, tag 0.
- Simultaneous clr and en: clr wins (see above).
- Reset mid-operation: all contents are lost immediately; there is no partial flush.
- X handling: an X on din propagates as data. din_vld X is not required to be resolved; the bench drives known values.

Optional Feature:
- Macro: D_FF_PIPE_TAPS_EN.
- When defined:
  - adds output port taps, WIDTH*DEPTH bits, with stage i at bits [i*WIDTH +: WIDTH].
  - adds output port taps_vld, DEPTH bits, with bit i = vld[i].
  - Both are direct register views with no extra latency, and both follow the reset/clear values above.
- When undefined: neither port exists; behaviour and timing of all other ports are identical.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=8'h00):
- Reset: assert n_rst=0 mid-cycle with the pipeline full -> dout=8'h00, dout_vld=0, occ=0 immediately, without waiting for a clk edge.
- Latency: en=1, din=8'hA5 with din_vld=1 for one cycle, then din_vld=0 -> dout=8'hA5 and dout_vld=1 exactly on the 4th edge after acceptance, for one cycle only.
- Stall: stream 8'h01..8'h04 valid, with en=0 for 3 cycles after the 2nd word -> outputs and occ frozen during the stall; 01,02,03,04 emerge in order with latency 4+3 for words 1 and 2.
- Fill/occ: 6 consecutive valid words with en=1 -> occ counts 1,2,3,4,4,4. Then din_vld=0 for 4 cycles -> occ 3,2,1,0.
- Clear vs enable: pipeline full (occ=4), clr=1 and en=1 with din=8'hFF, din_vld=1 -> next edge occ=0, dout_vld=0, dout=8'h00; 8'hFF never appears.
- Taps (with D_FF_PIPE_TAPS_EN): feed 8'h11,22,33,44 -> taps=32'h11223344 (stage3..stage0 MSB-first), taps_vld=4'b1111.
